// File: rtl/banner_scroller_if.sv
// ---------------------------------------------------------------------------
// banner_scroller_if
//   Bundles the message-buffer write port, the scroll controls and the
//   display-side outputs of banner_scroller. clk and reset stay as plain
//   ports on the modules.
//
//   master : the controller that loads glyphs and drives go/stop/pause/dir.
//            It observes the display outputs.
//   slave  : banner_scroller itself.
//
//   Signals
//     wr_en, wr_addr[AW-1:0], wr_data[4:0] : glyph write into the buffer
//     len[AW:0]                            : message length, sampled on go
//     go, stop, pause, dir                 : scroll control
//     hex2, hex1, hex0 [4:0]               : window codes, left to right
//     dp_out[2:0], en_out[2:0]             : bit0 = hex2 ... bit2 = hex0
//     busy, wrap_pulse                     : status
// ---------------------------------------------------------------------------
interface banner_scroller_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [4:0]    wr_data;
    logic [AW:0]   len;
    logic          go;
    logic          stop;
    logic          pause;
    logic          dir;

    logic [4:0]    hex2;
    logic [4:0]    hex1;
    logic [4:0]    hex0;
    logic [2:0]    dp_out;
    logic [2:0]    en_out;
    logic          busy;
    logic          wrap_pulse;

    modport master (
        output wr_en, wr_addr, wr_data, len, go, stop, pause, dir,
        input  hex2, hex1, hex0, dp_out, en_out, busy, wrap_pulse
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len, go, stop, pause, dir,
        output hex2, hex1, hex0, dp_out, en_out, busy, wrap_pulse
    );
endinterface

// File: rtl/banner_scroller.sv
// ---------------------------------------------------------------------------
// banner_scroller
//   Holds a message of up to MSG_LEN 5-bit glyph codes and scrolls a
//   3-symbol window across it, one step every TICK_DIV clocks. The window
//   codes, decimal points and digit enables feed a 3-digit seven-segment
//   multiplexer directly.
//
//   Ports
//     clk    : system clock
//     reset  : asynchronous, active-high
//     bus    : banner_scroller_if.slave
//              write port  wr_en / wr_addr / wr_data
//              controls    len (sampled on go), go, stop, pause (level), dir
//              outputs     hex2/hex1/hex0, dp_out, en_out, busy, wrap_pulse
//
//   Window: hex2 = msg[pos], hex1 = msg[(pos+1) mod len], hex0 =
//   msg[(pos+2) mod len]. A decimal point lights on whichever digit shows
//   buffer index 0 so the viewer can see where the message starts.
//   All outputs are registered; they follow pos and the buffer one cycle
//   later. wrap_pulse is registered on the step edge itself, so it is high
//   in the cycle right after the step that crossed the boundary.
// ---------------------------------------------------------------------------
module banner_scroller #(
    parameter int MSG_LEN  = 16,
    parameter int AW       = 4,
    parameter int TICK_DIV = 12000000
) (
    input  logic              clk,
    input  logic              reset,
    banner_scroller_if.slave  bus
);

    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [4:0]    BLANK     = 5'h12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] pos_reg,   pos_next;
    logic [TW-1:0] tick_reg,  tick_next;
    logic [AW:0]   len_reg,   len_next;
    logic          wrap_next;

    logic [4:0]    hex2_reg, hex1_reg, hex0_reg;
    logic [2:0]    dp_reg;
    logic [2:0]    en_reg;
    logic          busy_reg;
    logic          wrap_reg;

    // Message buffer. Contents survive reset on purpose so a message can be
    // loaded once and replayed.
    logic [4:0]    msg_mem [MSG_LEN];

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            msg_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // go with a zero length is treated as if it never happened.
    logic        start;
    logic [AW:0] len_m1;

    assign start  = bus.go && (bus.len != '0);
    assign len_m1 = len_reg - (AW+1)'(1);

    // -----------------------------------------------------------------------
    // Window index chain. Each index is the previous plus one, folded back
    // by subtracting len_reg, so lengths that are not a power of two (and
    // lengths of 1 or 2, where symbols repeat) wrap correctly.
    // -----------------------------------------------------------------------
    logic [AW:0] win_idx  [3];
    logic [AW:0] win_inc  [2];
    logic [4:0]  win_code [3];
    logic [2:0]  win_dp;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win
            if (gi == 0) begin : g_first
                assign win_idx[gi] = {1'b0, pos_reg};
            end else begin : g_next
                assign win_idx[gi] = (win_inc[gi-1] >= len_reg)
                                   ? (win_inc[gi-1] - len_reg)
                                   : win_inc[gi-1];
            end

            if (gi < 2) begin : g_inc
                assign win_inc[gi] = win_idx[gi] + (AW+1)'(1);
            end

            assign win_code[gi] = msg_mem[win_idx[gi][AW-1:0]];
            assign win_dp[gi]   = (win_idx[gi] == '0);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic: control FSM plus tick counter and position.
    // Priority is stop > go > pause.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        tick_next  = tick_reg;
        len_next   = len_reg;
        wrap_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                tick_next = '0;
                if (start && !bus.stop) begin
                    state_next = RUN;
                    len_next   = bus.len;
                    pos_next   = '0;
                end
            end

            RUN, PAUSED: begin
                if (bus.stop) begin
                    state_next = IDLE;
                    pos_next   = '0;
                    tick_next  = '0;
                end else if (start) begin
                    // Restart from the top of the message with a fresh length.
                    state_next = bus.pause ? PAUSED : RUN;
                    len_next   = bus.len;
                    pos_next   = '0;
                    tick_next  = '0;
                end else if (state_reg == RUN) begin
                    // pause freezes immediately: the counter does not advance
                    // on the edge that moves us into PAUSED.
                    if (bus.pause) begin
                        state_next = PAUSED;
                    end else if (tick_reg == TICK_LAST) begin
                        tick_next = '0;
                        if (!bus.dir) begin
                            if ({1'b0, pos_reg} == len_m1) begin
                                pos_next  = '0;
                                wrap_next = 1'b1;
                            end else begin
                                pos_next  = pos_reg + 1'b1;
                            end
                        end else begin
                            if (pos_reg == '0) begin
                                pos_next  = len_m1[AW-1:0];
                                wrap_next = 1'b1;
                            end else begin
                                pos_next  = pos_reg - 1'b1;
                            end
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end else if (!bus.pause) begin
                    state_next = RUN;
                end
            end

            default: begin
                state_next = IDLE;
                pos_next   = '0;
                tick_next  = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            pos_reg   <= '0;
            tick_reg  <= '0;
            len_reg   <= '0;
            wrap_reg  <= 1'b0;
            hex2_reg  <= BLANK;
            hex1_reg  <= BLANK;
            hex0_reg  <= BLANK;
            dp_reg    <= 3'b000;
            en_reg    <= 3'b000;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pos_reg   <= pos_next;
            tick_reg  <= tick_next;
            len_reg   <= len_next;
            wrap_reg  <= wrap_next;

            if (state_reg != IDLE) begin
                hex2_reg <= win_code[0];
                hex1_reg <= win_code[1];
                hex0_reg <= win_code[2];
                dp_reg   <= win_dp;
                en_reg   <= 3'b111;
                busy_reg <= 1'b1;
            end else begin
                hex2_reg <= BLANK;
                hex1_reg <= BLANK;
                hex0_reg <= BLANK;
                dp_reg   <= 3'b000;
                en_reg   <= 3'b000;
                busy_reg <= 1'b0;
            end
        end
    end

    assign bus.hex2       = hex2_reg;
    assign bus.hex1       = hex1_reg;
    assign bus.hex0       = hex0_reg;
    assign bus.dp_out     = dp_reg;
    assign bus.en_out     = en_reg;
    assign bus.busy       = busy_reg;
    assign bus.wrap_pulse = wrap_reg;

endmodule

// File: doc/banner_scroller.md
Name: banner_scroller

Overview:
Upstream feeder for the 3-digit seven-segment multiplexer. Holds a message of up to MSG_LEN 5-bit glyph codes and scrolls a 3-symbol window across it at a programmable rate. Each window symbol is presented as a code (0x00-0x0F hex, 0x10-0x17 special glyphs, 0x12 blank) with per-digit decimal-point and enable bits. Outputs drive the multiplexer's hex2/hex1/hex0, dp and enable inputs directly.

Parameters:
MSG_LEN, 16, message buffer depth in symbols (power of 2, >=4)
AW, 4, buffer address width, log2(MSG_LEN)
TICK_DIV, 12000000, clk cycles per scroll step (1 s at 12 MHz); >=2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
wr_en  in  1  write one glyph into buffer this cycle
wr_addr  in  AW  buffer write address
wr_data  in  5  glyph code to write
len  in  AW+1  active message length, 0..MSG_LEN; sampled on go
go  in  1  start scrolling from index 0 (single-cycle pulse)
stop  in  1  return to IDLE
pause  in  1  level; freeze scrolling while high
dir  in  1  0 = scroll left (index increments), 1 = scroll right (index decrements)
hex2  out  5  leftmost digit code = msg[pos]
hex1  out  5  middle digit code = msg[(pos+1) mod len_r]
hex0  out  5  rightmost digit code = msg[(pos+2) mod len_r]
dp_out  out  3  decimal points; bit0 pairs with hex2, bit2 with hex0; active high
en_out  out  3  digit enables; bit0 pairs with hex2, bit2 with hex0; active high
busy  out  1  high in RUN or PAUSED
wrap_pulse  out  1  one-cycle strobe when pos wraps

Behaviour:
- Reset (async): state=IDLE, pos=0, tick counter=0, len_r=0. hex2/hex1/hex0=0x12 (blank), dp_out=000, en_out=000, busy=0, wrap_pulse=0. Buffer contents are not reset.
- Buffer: MSG_LEN x 5 register file. Synchronous write on wr_en in any state. A write takes effect on the outputs in the next output update, i.e. 1 cycle after the write edge if the location is in the window.
- States:
  IDLE -> RUN on go when len!=0. Capture len_r=len, pos=0, tick=0. go with len=0 is ignored.
  RUN -> PAUSED when pause=1. PAUSED -> RUN when pause=0.
  RUN/PAUSED -> IDLE on stop.
  go in RUN/PAUSED restarts: recapture len, pos=0, tick=0. The state remains or becomes RUN if pause=0.
  Priority: reset > stop > go > pause.
- Tick: in RUN, the counter counts 0..TICK_DIV-1. At TICK_DIV-1 it returns to 0 and pos steps once. In PAUSED, the counter and pos hold. In IDLE, the counter is held at 0.
- Step, dir=0: pos = (pos==len_r-1) ? 0 : pos+1. Step, dir=1: pos = (pos==0) ? len_r-1 : pos-1.
- wrap_pulse is high for exactly the cycle after a step that crosses the boundary (len_r-1->0 or 0->len_r-1). With len_r=1, every step wraps.
- Window indices are mod len_r. Wrap is computed by compare/subtract, not by AW-bit overflow, so non-power-of-2 lengths work. For len_r=1 or 2, symbols repeat across digits.
- Outputs are registered and update every cycle from the current pos/buffer. Latency is 1 cycle from a pos change or a write.
  In RUN/PAUSED: en_out=111. dp_out bit k=1 iff that digit shows buffer index 0 (marks message start).
  In IDLE: hex*=0x12, en_out=000, dp_out=000.
  busy is registered alongside the outputs.
- dir may change at any time; it takes effect on the next step.
- len changes outside go are ignored.

Test Plan:
- Reset mid-RUN with TICK_DIV=4: assert reset -> outputs immediately hex*=0x12, en=000, busy=0. After release, state is IDLE until go.
- Load "1,2,3,4,5" (len=5), go, dir=0, TICK_DIV=4 -> the window sequence is:
  - hex2/1/0 = 1,2,3 with dp_out=001
  - after 4 clk: 2,3,4
  - then 3,4,5; 4,5,1 (dp=100); 5,1,2 (dp=010); 1,2,3
  - wrap_pulse fires once, on the 5->1 transition.
- Same message, dir=1 -> first step gives 5,1,2 with wrap_pulse. The next step gives 4,5,1.
- Pause for 10 cycles mid-tick -> pos and counter are frozen. The step occurs exactly (TICK_DIV - elapsed) RUN cycles after pause drops.
- len=1 containing 0x0A -> all digits show 0x0A, dp_out=111, wrap_pulse on every step. Separately, go with len=0 -> state stays IDLE, busy=0.
- Write 0x11 to an address currently in the window during RUN -> the corresponding hex output shows 0x11 one cycle later. stop together with go -> IDLE.
